// File: rtl/scan_scheduler.sv
// Row-scan / bit-plane (BCM) sequencer. Requests the next plane from the serial
// shifter while the current one is displayed, then blanks, latches and re-lights the panel.
module scan_scheduler #(
    parameter int NUM_ROWS     = 16,
    parameter int BIT_DEPTH    = 8,
    parameter int BASE_TICKS   = 64,
    parameter int BLANK_CYCLES = 4,
    localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int PLANE_W = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [7:0]          brightness,
    input  logic                shift_done,
    output logic                shift_start,
    output logic [ROW_W-1:0]    shift_row,
    output logic [PLANE_W-1:0]  shift_plane,
    output logic                latch_enable,
    output logic                output_enable_n,
    output logic [NUM_ROWS-1:0] row_select_n,
    output logic                frame_done
);
    localparam int MAX_PERIOD = BASE_TICKS << (BIT_DEPTH - 1);
    localparam int PER_W      = $clog2(MAX_PERIOD + 1);
    localparam int PROD_W     = PER_W + 9;
    localparam int BLK_W      = $clog2(BLANK_CYCLES + 1);

    localparam logic [ROW_W-1:0]   LAST_ROW    = ROW_W'(NUM_ROWS - 1);
    localparam logic [PLANE_W-1:0] LAST_PLANE  = PLANE_W'(BIT_DEPTH - 1);
    localparam logic [BLK_W-1:0]   LAST_BLANK  = BLK_W'(BLANK_CYCLES - 1);
    localparam logic [PER_W-1:0]   BASE_PERIOD = PER_W'(BASE_TICKS);

    typedef enum logic [2:0] {IDLE, PRIME, BLANK, LATCH, DISPLAY} state_t;

    state_t                state_reg, state_next;
    logic [ROW_W-1:0]      shift_row_reg, shift_row_next;
    logic [PLANE_W-1:0]    shift_plane_reg, shift_plane_next;
    logic [ROW_W-1:0]      disp_row_reg, disp_row_next;
    logic [PLANE_W-1:0]    disp_plane_reg, disp_plane_next;
    logic [PER_W-1:0]      timer_reg, timer_next;
    logic [PER_W-1:0]      period_reg, period_next;
    logic [PER_W-1:0]      on_len_reg, on_len_next;
    logic [BLK_W-1:0]      blank_cnt_reg, blank_cnt_next;
    logic                  shift_ready_reg, shift_ready_next;
    logic                  shift_start_reg, shift_start_next;
    logic                  latch_reg, latch_next;
    logic                  oe_n_reg, oe_n_next;
    logic [NUM_ROWS-1:0]   row_sel_reg, row_sel_next;
    logic                  frame_done_reg, frame_done_next;

    logic [ROW_W-1:0]      adv_row;
    logic [PLANE_W-1:0]    adv_plane;
    logic                  adv_wrap;
    logic [PER_W-1:0]      new_period;
    logic [8:0]            bright_inc;
    logic [PROD_W-1:0]     on_prod;
    logic [PER_W-1:0]      new_on_len;
    logic [PER_W-1:0]      timer_inc;

    // on-time is computed at full product width so brightness 255 yields the whole period
    assign new_period = BASE_PERIOD << disp_plane_reg;
    assign bright_inc = {1'b0, brightness} + 9'd1;
    assign on_prod    = PROD_W'(new_period) * PROD_W'(bright_inc);
    assign new_on_len = PER_W'(on_prod >> 8);
    assign timer_inc  = timer_reg + PER_W'(1);

    always_comb begin
        adv_row   = shift_row_reg;
        adv_plane = shift_plane_reg + PLANE_W'(1);
        adv_wrap  = 1'b0;
        if (shift_plane_reg == LAST_PLANE) begin
            adv_plane = '0;
            if (shift_row_reg == LAST_ROW) begin
                adv_row  = '0;
                adv_wrap = 1'b1;
            end else begin
                adv_row = shift_row_reg + ROW_W'(1);
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        shift_row_next   = shift_row_reg;
        shift_plane_next = shift_plane_reg;
        disp_row_next    = disp_row_reg;
        disp_plane_next  = disp_plane_reg;
        timer_next       = timer_reg;
        period_next      = period_reg;
        on_len_next      = on_len_reg;
        blank_cnt_next   = blank_cnt_reg;
        shift_ready_next = shift_ready_reg;
        shift_start_next = 1'b0;
        latch_next       = 1'b0;
        frame_done_next  = 1'b0;
        oe_n_next        = 1'b1;
        row_sel_next     = '1;

        case (state_reg)
            IDLE: begin
                shift_row_next   = '0;
                shift_plane_next = '0;
                disp_row_next    = '0;
                disp_plane_next  = '0;
                timer_next       = '0;
                blank_cnt_next   = '0;
                shift_ready_next = 1'b0;
                if (enable) begin
                    state_next       = PRIME;
                    shift_start_next = 1'b1;
                end
            end
            PRIME: begin
                if (shift_done) begin
                    state_next     = BLANK;
                    blank_cnt_next = '0;
                end
            end
            BLANK: begin
                if (blank_cnt_reg == LAST_BLANK) begin
                    if (!enable) begin
                        state_next       = IDLE;
                        shift_row_next   = '0;
                        shift_plane_next = '0;
                        disp_row_next    = '0;
                        disp_plane_next  = '0;
                        timer_next       = '0;
                        blank_cnt_next   = '0;
                        shift_ready_next = 1'b0;
                    end else begin
                        // registered outputs: the latch actions land on the LATCH cycle itself
                        state_next       = LATCH;
                        latch_next       = 1'b1;
                        disp_row_next    = shift_row_reg;
                        disp_plane_next  = shift_plane_reg;
                        shift_row_next   = adv_row;
                        shift_plane_next = adv_plane;
                        frame_done_next  = adv_wrap;
                    end
                end else begin
                    blank_cnt_next = blank_cnt_reg + BLK_W'(1);
                end
            end
            LATCH: begin
                state_next       = DISPLAY;
                period_next      = new_period;
                on_len_next      = new_on_len;
                timer_next       = '0;
                shift_ready_next = 1'b0;
                shift_start_next = 1'b1;
                row_sel_next     = ~(NUM_ROWS'(1) << disp_row_reg);
                oe_n_next        = (new_on_len == '0);
            end
            DISPLAY: begin
                row_sel_next = row_sel_reg;
                if (shift_done) begin
                    shift_ready_next = 1'b1;
                end
                if (timer_reg == period_reg - PER_W'(1)) begin
                    // period spent: leave only once the next plane is in the shifter
                    if (shift_ready_reg || shift_done) begin
                        state_next     = BLANK;
                        blank_cnt_next = '0;
                        row_sel_next   = '1;
                    end
                end else begin
                    timer_next = timer_inc;
                    oe_n_next  = !(timer_inc < on_len_reg);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            shift_row_reg   <= '0;
            shift_plane_reg <= '0;
            disp_row_reg    <= '0;
            disp_plane_reg  <= '0;
            timer_reg       <= '0;
            period_reg      <= '0;
            on_len_reg      <= '0;
            blank_cnt_reg   <= '0;
            shift_ready_reg <= 1'b0;
            shift_start_reg <= 1'b0;
            latch_reg       <= 1'b0;
            oe_n_reg        <= 1'b1;
            row_sel_reg     <= '1;
            frame_done_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shift_row_reg   <= shift_row_next;
            shift_plane_reg <= shift_plane_next;
            disp_row_reg    <= disp_row_next;
            disp_plane_reg  <= disp_plane_next;
            timer_reg       <= timer_next;
            period_reg      <= period_next;
            on_len_reg      <= on_len_next;
            blank_cnt_reg   <= blank_cnt_next;
            shift_ready_reg <= shift_ready_next;
            shift_start_reg <= shift_start_next;
            latch_reg       <= latch_next;
            oe_n_reg        <= oe_n_next;
            row_sel_reg     <= row_sel_next;
            frame_done_reg  <= frame_done_next;
        end
    end

    assign shift_start     = shift_start_reg;
    assign shift_row       = shift_row_reg;
    assign shift_plane     = shift_plane_reg;
    assign latch_enable    = latch_reg;
    assign output_enable_n = oe_n_reg;
    assign row_select_n    = row_sel_reg;
    assign frame_done      = frame_done_reg;
endmodule

// File: doc/scan_scheduler.md
# scan_scheduler

Sequences the cube's row-scan and binary-code-modulation (BCM) display cycle. The block sits between the frame-buffer/shift-register driver and the panel control pins: it tells the serial shifter when and what to shift, then drives blanking, the latch pulse, the row select and weighted output-enable timing. Shifting of the next bit plane overlaps display of the current one.

## Interface
- NUM_ROWS, 16, rows scanned (one-hot row select width)
- BIT_DEPTH, 8, bit planes per color channel
- BASE_TICKS, 64, clk cycles of display period for plane 0; plane p period = BASE_TICKS << p
- BLANK_CYCLES, 4, cycles of forced blanking before each latch (ghosting guard), >= 1
- clk  input  1  system clock (50 MHz)
- reset_n  input  1  synchronous, active-low reset
- enable  input  1  run scanning; sampled as described below
- brightness  input  8  global dimmer, sampled at each LATCH
- shift_done  input  1  one-cycle pulse from shifter: requested row/plane fully shifted
- shift_start  output  1  one-cycle pulse: shifter begins shifting shift_row/shift_plane
- shift_row  output  clog2(NUM_ROWS)  row address the shifter must load
- shift_plane  output  clog2(BIT_DEPTH)  bit plane the shifter must load
- latch_enable  output  1  one-cycle latch pulse to drivers
- output_enable_n  output  1  active-low driver output enable
- row_select_n  output  NUM_ROWS  active-low one-hot row select
- frame_done  output  1  one-cycle pulse: last plane of a frame handed to displays, shifter wraps to (0,0)

## Operation
- All outputs registered. Reset (reset_n low at a clk edge): state IDLE, row_select_n all 1, output_enable_n 1, latch_enable 0, shift_start 0, frame_done 0, shift_row/shift_plane 0, display pointer (0,0), timers 0, shift_pending flag 0.
- Scan order: plane increments fastest; after plane BIT_DEPTH-1 row increments; after (NUM_ROWS-1, BIT_DEPTH-1) wraps to (0,0).
- IDLE: outputs as reset. enable=1 sampled -> PRIME, shift_start pulses next cycle with shift pointer (0,0).
- PRIME: wait shift_done -> BLANK. Panel stays dark.
- BLANK: output_enable_n 1, row_select_n all 1, hold BLANK_CYCLES cycles. On last cycle: enable=0 -> IDLE (pointers reset to 0); else -> LATCH.
- LATCH (1 cycle): latch_enable 1; display pointer <= shift pointer; shift pointer advances; on_len registered from new display plane; frame_done 1 if shift pointer wraps to (0,0). -> DISPLAY.
- DISPLAY: row_select_n = ~(1 << disp_row); shift_start pulses on first DISPLAY cycle with the advanced shift pointer; timer counts 0..period-1; output_enable_n 0 while timer < on_len, else 1.
- shift_done sets sticky shift_ready (cleared at LATCH). DISPLAY exits to BLANK after timer reaches period-1 AND shift_ready (shift_done in that same cycle counts). Timer expired without shift_ready: stall in DISPLAY, output_enable_n 1, row_select_n held.
- on_len = (period * (brightness + 1)) >> 8, computed at full width (period width + 9 bits); brightness 255 -> on_len = period.
- shift_done outside PRIME/DISPLAY ignored. enable changes mid-DISPLAY take effect only at end of next BLANK.

## Timing
- enable sampled high in IDLE at edge k -> shift_start high cycle k+1 (one clock).
- shift_done at edge j in PRIME -> BLANK from j+1 for BLANK_CYCLES, LATCH one cycle, DISPLAY from next cycle.
- Unstalled per-plane interval = period + BLANK_CYCLES + 1 cycles.
- output_enable_n and row_select_n never active in the same cycle as latch_enable; row_select_n changes only during BLANK/LATCH (all high).
- Reset asserted mid-DISPLAY: next cycle all outputs at reset values; any in-flight shift is abandoned.

## Test plan
- Params NUM_ROWS=4, BIT_DEPTH=2, BASE_TICKS=4, BLANK_CYCLES=2, shifter model returns shift_done 3 cycles after shift_start, brightness=255: shift_start sequence (0,0),(0,1),(1,0)...(3,1),(0,0); output_enable_n low exactly 4 then 8 cycles alternating; row_select_n 1110,1110,1101,...
- Same params, brightness=127: plane 1 (period 8) output_enable_n low 4 cycles; plane 0 low 2; brightness=0: plane 0 low 0 cycles, plane 1 low 0 cycles.
- Shifter delay 20 cycles: DISPLAY stalls; output_enable_n 1 after on_len, latch only after shift_done; no extra shift_start.
- frame_done pulses once per 8 latches, coincident with latch_enable when display pointer becomes (3,1).
- enable dropped mid-DISPLAY: finishes plane, BLANK, then IDLE with no latch; re-enable restarts at (0,0) via PRIME.
- reset_n low for one cycle mid-DISPLAY: next cycle output_enable_n 1, row_select_n 1111, latch_enable 0, shift_start 0; restart behaves as from power-up.
